mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter WORD_NUM, default 4, words per cache line; power of two, at least 2.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-low reset.
REQ-005 SHALL have ports per requester n in {0,1} (n=0 I-cache, n=1 D-cache):
- reqn_i  in  1  line transfer request.
- reqn_adr_i  in  ADR_WIDTH  critical-word byte address.
- reqn_rdwr_i  in  1  0=refill read, 1=victim writeback.
- reqn_dat_i  in  WORD_WIDTH  writeback data.
- reqn_ack_o  out  1  beat done.
- reqn_dat_o  out  WORD_WIDTH  refill data.
- reqn_word_o  out  log2(WORD_NUM)  word index of the current beat.
REQ-006 SHALL have memory ports:
- mem_req_o  out  1  beat request.
- mem_adr_o  out  ADR_WIDTH  word-aligned beat address.
- mem_rdwr_o  out  1  beat direction.
- mem_dat_o  out  WORD_WIDTH  write data.
- mem_ack_i  in  1  beat done.
- mem_dat_i  in  WORD_WIDTH  read data.
REQ-007 SHALL have status output grant_o  out  2  one-hot current owner; 00 when idle.

Function
REQ-008 SHALL implement a 3-state FSM: IDLE, BURST, RELEASE.
REQ-009 In IDLE with at least one reqn_i high, the FSM SHALL pick a winner and latch its address and rdwr, and SHALL enter BURST on the next edge.
REQ-010 With both requests high in IDLE, the winner SHALL be the requester that was not granted last; after reset, requester 0 wins the first tie.
REQ-011 In BURST, mem_req_o SHALL be 1 and mem_adr_o SHALL equal {latched line address, beat index, byte offset zeroed}.
REQ-012 The beat index SHALL start at the latched word offset and SHALL increment modulo WORD_NUM on each mem_ack_i.
REQ-013 In BURST, mem_dat_o and mem_rdwr_o SHALL come from the owner's reqn_dat_i and the latched rdwr.
REQ-014 On each mem_ack_i in BURST, the owner's reqn_ack_o SHALL pulse for that same cycle, combinationally.
REQ-015 In that cycle, reqn_dat_o SHALL equal mem_dat_i and reqn_word_o SHALL equal the beat index before increment.
REQ-016 The non-owner's reqn_ack_o SHALL stay 0 throughout.
REQ-017 After exactly WORD_NUM acked beats, the FSM SHALL enter RELEASE. RELEASE SHALL last one cycle with mem_req_o=0 and grant_o=00, then return to IDLE.
REQ-018 If the owner drops reqn_i mid-burst, the burst SHALL still complete all WORD_NUM beats; acks are still pulsed.
REQ-019 A request arriving during BURST or RELEASE SHALL wait and SHALL be arbitrated in IDLE; no request is lost while it is held high.
REQ-020 mem_ack_i outside BURST SHALL be ignored.
REQ-021 The minimum line transfer SHALL be WORD_NUM+2 cycles from IDLE to IDLE, with zero-wait memory.

Reset
REQ-022 With rst=0 at a clk edge, the FSM SHALL go to IDLE and all outputs SHALL read 0 (mem_req_o, mem_adr_o, mem_rdwr_o, mem_dat_o, reqn_ack_o, reqn_dat_o, reqn_word_o, grant_o). The last-grant pointer SHALL be set to requester 1.
REQ-023 Reset asserted mid-burst SHALL abandon the burst immediately; no ack SHALL be issued in the reset cycle.

Configuration
REQ-024 With macro MEM_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-010. Without it, requester 1 (D-cache) SHALL always win ties and the last-grant pointer SHALL be omitted.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single refill: req0_i=1, adr 0x0000_1008, rdwr 0, mem_ack_i every cycle -> mem_adr_o 0x1008, 0x100C, 0x1000, 0x1004; req0_word_o 2,3,0,1; four req0_ack_o pulses; grant_o 01; back to IDLE after 6 cycles.
- Tie with MEM_ARB_RR_EN, both requests held -> grants 01, 10, 01 in successive transfers, each separated by one RELEASE cycle.
- Tie without MEM_ARB_RR_EN -> requester 1 is granted every transfer while req1_i stays high.
- Writeback with stalled memory: req1 rdwr 1, adr 0x40, mem_ack_i one cycle in three -> mem_rdwr_o=1 and mem_req_o held high throughout; exactly 4 acks; req0_ack_o stays 0.
- Reset mid-burst: rst=0 after 2 beats -> the next cycle shows all outputs 0; a fresh req0_i starts from its own word offset.
- Owner drops request after 1 beat -> 3 more beats are still issued, then RELEASE; a stray mem_ack_i in IDLE produces no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester cache-line arbiter: grants I-cache (0) or D-cache (1) a WORD_NUM-beat
// wrapping burst to memory. Define MEM_ARB_RR_EN for round-robin ties; otherwise D-cache wins.
module mem_arbiter #(
   parameter int WORD_WIDTH = 32,
   parameter int ADR_WIDTH  = 32,
   parameter int WORD_NUM   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req0_i,
   input  logic [ADR_WIDTH-1:0]        req0_adr_i,
   input  logic                        req0_rdwr_i,
   input  logic [WORD_WIDTH-1:0]       req0_dat_i,
   output logic                        req0_ack_o,
   output logic [WORD_WIDTH-1:0]       req0_dat_o,
   output logic [$clog2(WORD_NUM)-1:0] req0_word_o,
   input  logic                        req1_i,
   input  logic [ADR_WIDTH-1:0]        req1_adr_i,
   input  logic                        req1_rdwr_i,
   input  logic [WORD_WIDTH-1:0]       req1_dat_i,
   output logic                        req1_ack_o,
   output logic [WORD_WIDTH-1:0]       req1_dat_o,
   output logic [$clog2(WORD_NUM)-1:0] req1_word_o,
   output logic                        mem_req_o,
   output logic [ADR_WIDTH-1:0]        mem_adr_o,
   output logic                        mem_rdwr_o,
   output logic [WORD_WIDTH-1:0]       mem_dat_o,
   input  logic                        mem_ack_i,
   input  logic [WORD_WIDTH-1:0]       mem_dat_i,
   output logic [1:0]                  grant_o
);

   localparam int WB = $clog2(WORD_NUM);
   localparam int BO = $clog2(WORD_WIDTH / 8);
   localparam int LW = ADR_WIDTH - WB - BO;

   typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

   state_t          state, state_next;
   logic            owner, owner_next;
   logic            rdwr, rdwr_next;
   logic [LW-1:0]   line, line_next;
   logic [WB-1:0]   beat, beat_next;
   logic [WB-1:0]   cnt, cnt_next;
   logic            pick, tie_pick;
   logic [ADR_WIDTH-1:0] adr_sel;
   logic            unused_adr;
   logic            in_burst, ack;

`ifdef MEM_ARB_RR_EN
   logic            last, last_next;
   assign tie_pick = ~last;
`else
   assign tie_pick = 1'b1;
`endif

   assign pick       = (req0_i && req1_i) ? tie_pick : req1_i;
   assign adr_sel    = pick ? req1_adr_i : req0_adr_i;
   // Byte-offset bits of the request address never reach memory.
   assign unused_adr = ^adr_sel;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         owner <= 1'b0;
         rdwr  <= 1'b0;
         line  <= '0;
         beat  <= '0;
         cnt   <= '0;
`ifdef MEM_ARB_RR_EN
         last  <= 1'b1;
`endif
      end else begin
         state <= state_next;
         owner <= owner_next;
         rdwr  <= rdwr_next;
         line  <= line_next;
         beat  <= beat_next;
         cnt   <= cnt_next;
`ifdef MEM_ARB_RR_EN
         last  <= last_next;
`endif
      end
   end

   // The beat index wraps naturally in WB bits; cnt counts acked beats.
   always_comb begin
      state_next = state;
      owner_next = owner;
      rdwr_next  = rdwr;
      line_next  = line;
      beat_next  = beat;
      cnt_next   = cnt;
`ifdef MEM_ARB_RR_EN
      last_next  = last;
`endif
      case (state)
         IDLE: begin
            if (req0_i || req1_i) begin
               owner_next = pick;
               rdwr_next  = pick ? req1_rdwr_i : req0_rdwr_i;
               line_next  = adr_sel[ADR_WIDTH-1 -: LW];
               beat_next  = adr_sel[BO +: WB];
               cnt_next   = '0;
`ifdef MEM_ARB_RR_EN
               last_next  = pick;
`endif
               state_next = BURST;
            end
         end
         BURST: begin
            if (mem_ack_i) begin
               beat_next = beat + WB'(1);
               cnt_next  = cnt + WB'(1);
               if (cnt == WB'(WORD_NUM - 1)) state_next = RELEASE;
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Acks are gated by rst so an abandoned burst never reports a beat.
   assign in_burst    = (state == BURST);
   assign ack         = in_burst & mem_ack_i & rst;

   assign mem_req_o   = in_burst;
   assign mem_adr_o   = in_burst ? (ADR_WIDTH'({line, beat}) << BO) : '0;
   assign mem_rdwr_o  = in_burst & rdwr;
   assign mem_dat_o   = in_burst ? (owner ? req1_dat_i : req0_dat_i) : '0;
   assign grant_o     = in_burst ? (owner ? 2'b10 : 2'b01) : 2'b00;

   assign req0_ack_o  = ack & ~owner;
   assign req1_ack_o  = ack & owner;
   assign req0_dat_o  = req0_ack_o ? mem_dat_i : '0;
   assign req1_dat_o  = req1_ack_o ? mem_dat_i : '0;
   assign req0_word_o = req0_ack_o ? beat : '0;
   assign req1_word_o = req1_ack_o ? beat : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected beats, a monitor pops them on acks.
module tb_mem_arbiter;

   localparam int WN = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_i, req0_rdwr_i, req0_ack_o;
   logic [31:0] req0_adr_i, req0_dat_i, req0_dat_o;
   logic [1:0]  req0_word_o;
   logic        req1_i, req1_rdwr_i, req1_ack_o;
   logic [31:0] req1_adr_i, req1_dat_i, req1_dat_o;
   logic [1:0]  req1_word_o;
   logic        mem_req_o, mem_rdwr_o, mem_ack_i;
   logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;
   logic [1:0]  grant_o;

   typedef struct {
      logic [1:0]  grant;
      logic [31:0] adr;
      logic [1:0]  word;
      logic        rdwr;
      logic [31:0] wdat;
   } beat_t;

   beat_t expQ[$];
   int    testsRun = 0;
   int    testsFailed = 0;
   int    ackMode = 0;
   int    cyc = 0;
   logic [1:0] tieGrant[3];

   mem_arbiter #(.WORD_WIDTH(32), .ADR_WIDTH(32), .WORD_NUM(WN)) dut (
      .clk(clk), .rst(rst),
      .req0_i(req0_i), .req0_adr_i(req0_adr_i), .req0_rdwr_i(req0_rdwr_i), .req0_dat_i(req0_dat_i),
      .req0_ack_o(req0_ack_o), .req0_dat_o(req0_dat_o), .req0_word_o(req0_word_o),
      .req1_i(req1_i), .req1_adr_i(req1_adr_i), .req1_rdwr_i(req1_rdwr_i), .req1_dat_i(req1_dat_i),
      .req1_ack_o(req1_ack_o), .req1_dat_o(req1_dat_o), .req1_word_o(req1_word_o),
      .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_rdwr_o(mem_rdwr_o), .mem_dat_o(mem_dat_o),
      .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i), .grant_o(grant_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushBeats(input logic [1:0] grant, input logic [31:0] adr, input logic rdwr,
                            input logic [31:0] wdat, input int n);
      logic [1:0] w;
      w = adr[3:2];
      for (int i = 0; i < n; i++) begin
         expQ.push_back('{grant, {adr[31:4], w, 2'b00}, w, rdwr, wdat});
         w = w + 2'd1;
      end
   endtask

   task automatic applyStimulus(input int who, input logic [31:0] adr, input logic rdwr, input logic [31:0] dat);
      if (who == 0) begin
         req0_i = 1'b1; req0_adr_i = adr; req0_rdwr_i = rdwr; req0_dat_i = dat;
      end else begin
         req1_i = 1'b1; req1_adr_i = adr; req1_rdwr_i = rdwr; req1_dat_i = dat;
      end
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (expQ.size() != 0) begin
         checkOutput({name, " drain timeout"}, 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " mem_req"},  32'(mem_req_o), 32'd0);
      checkOutput({tag, " mem_adr"},  mem_adr_o, 32'd0);
      checkOutput({tag, " mem_rdwr"}, 32'(mem_rdwr_o), 32'd0);
      checkOutput({tag, " mem_dat"},  mem_dat_o, 32'd0);
      checkOutput({tag, " acks"},     {30'd0, req1_ack_o, req0_ack_o}, 32'd0);
      checkOutput({tag, " dat_o"},    req0_dat_o | req1_dat_o, 32'd0);
      checkOutput({tag, " word_o"},   {28'd0, req1_word_o, req0_word_o}, 32'd0);
      checkOutput({tag, " grant"},    32'(grant_o), 32'd0);
   endtask

   // Memory model: fresh read data every cycle, ack pattern chosen by ackMode.
   initial begin
      mem_ack_i = 1'b0;
      mem_dat_i = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         mem_dat_i = 32'hA500_0000 + 32'(cyc);
         case (ackMode)
            1:       mem_ack_i = 1'b1;
            2:       mem_ack_i = (cyc % 3 == 0);
            default: mem_ack_i = 1'b0;
         endcase
      end
   end

   // Monitor: every ack must match the oldest expected beat.
   initial begin
      beat_t e;
      logic [1:0]  w;
      logic [31:0] d;
      forever begin
         @(negedge clk);
         if (req0_ack_o || req1_ack_o) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected ack", {30'd0, req1_ack_o, req0_ack_o}, 32'd0);
            end else begin
               e = expQ.pop_front();
               w = req1_ack_o ? req1_word_o : req0_word_o;
               d = req1_ack_o ? req1_dat_o : req0_dat_o;
               checkOutput("beat owner", {30'd0, req1_ack_o, req0_ack_o}, {30'd0, e.grant});
               checkOutput("beat grant", 32'(grant_o), 32'(e.grant));
               checkOutput("beat adr", mem_adr_o, e.adr);
               checkOutput("beat word", 32'(w), 32'(e.word));
               checkOutput("beat rdwr", 32'(mem_rdwr_o), 32'(e.rdwr));
               checkOutput("beat wdat", mem_dat_o, e.wdat);
               checkOutput("beat rdat", d, mem_dat_i);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit timedOut;
      rst = 1'b0;
      req0_i = 1'b0; req0_adr_i = '0; req0_rdwr_i = 1'b0; req0_dat_i = '0;
      req1_i = 1'b0; req1_adr_i = '0; req1_rdwr_i = 1'b0; req1_dat_i = '0;

      repeat (2) tick();
      @(negedge clk);
      checkAllZero("reset");
      tick();
      rst = 1'b1;

      // Tie with both requests held for three transfers.
`ifdef MEM_ARB_RR_EN
      tieGrant[0] = 2'b01; tieGrant[1] = 2'b10; tieGrant[2] = 2'b01;
`else
      tieGrant[0] = 2'b10; tieGrant[1] = 2'b10; tieGrant[2] = 2'b10;
`endif
      for (int t = 0; t < 3; t++) begin
         if (tieGrant[t] == 2'b01) pushBeats(2'b01, 32'h0000_0100, 1'b0, 32'h0A0A_0A0A, WN);
         else                      pushBeats(2'b10, 32'h0000_020C, 1'b0, 32'h1B1B_1B1B, WN);
      end
      ackMode = 1;
      applyStimulus(0, 32'h0000_0100, 1'b0, 32'h0A0A_0A0A);
      applyStimulus(1, 32'h0000_020C, 1'b0, 32'h1B1B_1B1B);
      for (int i = 0; i < 13; i++) begin
         tick();
         if (i == 12) begin
            req0_i = 1'b0;
            req1_i = 1'b0;
         end
         @(negedge clk);
         if (i == 0 || i == 6 || i == 12) checkOutput("tie grant", 32'(grant_o), 32'(tieGrant[i / 6]));
         if (i == 4 || i == 5) checkOutput("tie gap grant", 32'(grant_o), 32'd0);
      end
      waitDrain("tie", 40);
      repeat (2) tick();

      // Single refill with critical word 2.
      pushBeats(2'b01, 32'h0000_1008, 1'b0, 32'h0A0A_0A0A, WN);
      applyStimulus(0, 32'h0000_1008, 1'b0, 32'h0A0A_0A0A);
      tick();
      req0_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         if (i < 4) begin
            checkOutput("refill grant", 32'(grant_o), 32'd1);
            checkOutput("refill mem_req", 32'(mem_req_o), 32'd1);
         end else begin
            checkOutput("refill release grant", 32'(grant_o), 32'd0);
            checkOutput("refill release mem_req", 32'(mem_req_o), 32'd0);
            checkOutput("refill beats left", 32'(expQ.size()), 32'd0);
         end
      end
      tick();

      // Writeback from D-cache against a memory that acks one cycle in three.
      ackMode = 2;
      pushBeats(2'b10, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF, WN);
      applyStimulus(1, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
      tick();
      req1_i = 1'b0;
      timedOut = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         #1;
         checkOutput("wb mem_req", 32'(mem_req_o), 32'd1);
         checkOutput("wb mem_rdwr", 32'(mem_rdwr_o), 32'd1);
         checkOutput("wb req0_ack", 32'(req0_ack_o), 32'd0);
         if (expQ.size() == 0) begin
            timedOut = 1'b0;
            break;
         end
      end
      if (timedOut) begin
         checkOutput("wb drain timeout", 32'(expQ.size()), 32'd0);
         expQ.delete();
      end
      ackMode = 1;
      repeat (2) tick();

      // Owner drops its request after the first beat; stray acks follow in IDLE.
      pushBeats(2'b10, 32'h0000_0300, 1'b0, 32'h1B1B_1B1B, WN);
      applyStimulus(1, 32'h0000_0300, 1'b0, 32'h1B1B_1B1B);
      tick();
      tick();
      req1_i = 1'b0;
      waitDrain("drop", 20);
      @(negedge clk);
      checkOutput("drop release mem_req", 32'(mem_req_o), 32'd0);
      checkOutput("drop release grant", 32'(grant_o), 32'd0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("stray ack idle", {30'd0, req1_ack_o, req0_ack_o}, 32'd0);
         checkOutput("stray mem_req idle", 32'(mem_req_o), 32'd0);
      end
      tick();

      // Reset after two beats, then a fresh request from the same critical word.
      pushBeats(2'b01, 32'h0000_2004, 1'b0, 32'h0A0A_0A0A, 2);
      applyStimulus(0, 32'h0000_2004, 1'b0, 32'h0A0A_0A0A);
      tick();
      req0_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ack in reset cycle", 32'(req0_ack_o), 32'd0);
      checkOutput("beats before reset", 32'(expQ.size()), 32'd0);
      tick();
      rst = 1'b1;
      pushBeats(2'b01, 32'h0000_2004, 1'b0, 32'h0A0A_0A0A, WN);
      applyStimulus(0, 32'h0000_2004, 1'b0, 32'h0A0A_0A0A);
      @(negedge clk);
      checkAllZero("post reset");
      tick();
      req0_i = 1'b0;
      waitDrain("restart", 20);
      repeat (2) tick();

      checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
